echo_unit: RTL and testbench

- Post-envelope echo/delay stage. Sits directly downstream of the dynamics (envelope) stage and consumes its final_sample; its output feeds the codec conditioner.
- Each accepted sample is mixed with an attenuated copy of the output from delay_len samples earlier, held in a circular sample buffer.
- The mix saturates, so it never wraps.
- Echo can be bypassed, and the buffer can be flushed on song change.

---
 rtl/echo_unit_pkg.sv | 22 ++
 rtl/echo_ram.sv | 25 ++
 rtl/echo_unit.sv | 145 ++++++++++++++
 tb/tb_echo_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_unit_pkg.sv
// Shared definitions for the echo stage and other sample-mixing stages.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package echo_unit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    // Clamp a 17-bit signed sum into the 16-bit sample range. The sum can
    // only leave the range if its top two bits disagree; bit 16 is the true sign.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? SAMPLE_MIN : SAMPLE_MAX;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/echo_ram.sv
// Circular echo sample store: one write port, one registered read port.
// Latency: read data appears the cycle after the address; old data on a same-address write.
// Backpressure: none, accepts a write and a read every cycle.
module echo_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [15:0]           wr_dat,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [15:0]           rd_dat
);

    logic [15:0] mem [2**ADDR_WIDTH];

    // Array is deliberately unreset; the caller gates stale entries by fill level.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/echo_unit.sv
// Echo/delay stage: mixes each sample with an attenuated, saturated copy from delay_len samples ago.
// Latency: sample_valid in cycle N gives sample_out_valid in cycle N+2; one sample per 3 cycles max.
// Backpressure: none; a sample arriving while busy is dropped and raises the sticky overrun flag.
module echo_unit
    import echo_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int ATTEN_SHIFT = 1,
    parameter int FEEDBACK    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  echo_en,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    input  logic                  sample_valid,
    input  logic [15:0]           sample_in,
    output logic [15:0]           sample_out,
    output logic                  sample_out_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = {ADDR_WIDTH{1'b1}};

    logic [1:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH-1:0] fill_q,    fill_d;
    logic [ADDR_WIDTH-1:0] dly_q,     dly_d;
    logic [15:0]           sin_q,     sin_d;
    logic                  en_q,      en_d;
    logic [15:0]           out_q,     out_d;
    logic                  overrun_q, overrun_d;

    logic                  ram_we;
    logic [15:0]           ram_wd;
    logic [15:0]           ram_rd;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic signed [15:0]    delayed;
    logic signed [15:0]    shifted;
    logic [15:0]           wet;
    logic [15:0]           mix;

    // Read address is presented in IDLE from the live delay_len so data is ready in FETCH.
    assign rd_addr = wr_ptr_q - delay_len;

    echo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_dat  (ram_wd),
        .rd_addr (rd_addr),
        .rd_dat  (ram_rd)
    );

    // Mix datapath: delayed copy is silenced until enough history exists (or delay is zero).
    always_comb begin
        delayed = '0;
        if ((dly_q != '0) && (fill_q >= dly_q)) begin
            delayed = ram_rd;
        end
        shifted = delayed >>> ATTEN_SHIFT;
        wet     = sat16({sin_q[15], sin_q} + {shifted[15], shifted});
        mix     = en_q ? wet : sin_q;
        ram_wd  = ((FEEDBACK != 0) && en_q) ? mix : sin_q;
    end

    // Sequencing: accept in IDLE, mix and write back in FETCH, pulse valid in DONE.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        dly_d     = dly_q;
        sin_d     = sin_q;
        en_d      = en_q;
        out_d     = out_q;
        overrun_d = overrun_q;
        ram_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    sin_d   = sample_in;
                    dly_d   = delay_len;
                    en_d    = echo_en;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                out_d    = mix;
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (sample_valid && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
        // Flush overrides any pointer/fill advance in the same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end
    end

    // State registers; reset aborts any sample in flight without a write or output pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            dly_q     <= '0;
            sin_q     <= '0;
            en_q      <= 1'b0;
            out_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            dly_q     <= dly_d;
            sin_q     <= sin_d;
            en_q      <= en_d;
            out_q     <= out_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_out       = out_q;
    assign sample_out_valid = (state_q == ST_DONE);
    assign busy             = (state_q != ST_IDLE);
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_echo_unit.sv
module tb_echo_unit;

    localparam int AW = 4;
    localparam int SH = 1;
    localparam int FB = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          echo_en = 1'b0;
    logic [AW-1:0] delay_len = '0;
    logic          sample_valid = 1'b0;
    logic [15:0]   sample_in = '0;
    logic [15:0]   sample_out;
    logic          sample_out_valid;
    logic          busy;
    logic          overrun;

    echo_unit #(
        .ADDR_WIDTH  (AW),
        .ATTEN_SHIFT (SH),
        .FEEDBACK    (FB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .echo_en          (echo_en),
        .delay_len        (delay_len),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Behavioural model: history of stored samples since the last flush/reset.
    int hist[$];
    int acc    = -100;
    int l_sin  = 0;
    int l_dly  = 0;
    bit l_en   = 1'b0;
    int m_out  = 0;
    bit m_ovr  = 1'b0;

    // Observation logs for the directed literal checks.
    int outlog[$];
    int vldq[$];
    int litq[$];
    int busy_cnt = 0;
    int last_drv = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, evaluated per clock edge n from the port-level rules.
    always @(posedge clk or posedge reset) begin
        int n, dl, sum, wet, mix;
        if (reset) begin
            hist.delete();
            acc   = -100;
            m_out = 0;
            m_ovr = 1'b0;
        end else begin
            n = cyc + 1;
            if (n - acc == 1) begin
                dl = 0;
                if (l_dly != 0 && hist.size() >= l_dly) dl = hist[hist.size() - l_dly];
                sum = l_sin + (dl >>> SH);
                wet = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
                mix = l_en ? wet : l_sin;
                hist.push_back((FB != 0 && l_en) ? mix : l_sin);
                if (hist.size() > 64) void'(hist.pop_front());
                m_out = mix;
            end
            if (flush) hist.delete();
            if (sample_valid) begin
                if (n - acc == 1 || n - acc == 2) begin
                    m_ovr = 1'b1;
                end else begin
                    acc   = n;
                    l_sin = int'($signed(sample_in));
                    l_dly = int'(delay_len);
                    l_en  = echo_en;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("out_valid", int'(sample_out_valid), int'(cyc - acc == 1));
        chk("busy", int'(busy), int'(cyc - acc == 0 || cyc - acc == 1));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("sample_out", int'(sample_out), m_out & 32'hFFFF);
        if (sample_out_valid) begin
            outlog.push_back(int'(sample_out));
            vldq.push_back(cyc);
        end
        if (busy) busy_cnt++;
    end

    task automatic send(input logic [15:0] v, input int d, input logic en);
        @(posedge clk); #1;
        sample_in    = v;
        delay_len    = AW'(d);
        echo_en      = en;
        sample_valid = 1'b1;
        last_drv     = cyc;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        delay_len    = AW'($urandom);
        @(posedge clk);
    endtask

    task automatic do_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, outlog.size(), litq.size());
        foreach (litq[i]) begin
            if (i < outlog.size()) chk(nm, outlog[i], litq[i]);
        end
        litq.delete();
        outlog.delete();
        vldq.delete();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_valid", int'(sample_out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Dry path: exact latency and busy width
        do_flush();
        outlog.delete(); vldq.delete();
        busy_cnt = 0;
        send(16'h1234, 3, 1'b0);
        idle(4);
        chk("dry_busy_cycles", busy_cnt, 2);
        chk("dry_latency", (vldq.size() > 0) ? vldq[0] - last_drv : -1, 2);
        litq = '{32'h1234};
        check_log("dry");

        // Feedback echo, delay 2, -6 dB
        do_flush();
        outlog.delete(); vldq.delete();
        send(16'd800, 2, 1'b1);
        repeat (5) send(16'd0, 2, 1'b1);
        idle(4);
        litq = '{800, 0, 400, 0, 200, 0};
        check_log("feedback");

        // Saturation both rails, delay 1
        do_flush();
        outlog.delete(); vldq.delete();
        send(16'h7000, 1, 1'b1);
        send(16'h7000, 1, 1'b1);
        do_flush();
        send(16'h9000, 1, 1'b1);
        send(16'h9000, 1, 1'b1);
        idle(4);
        litq = '{32'h7000, 32'h7FFF, 32'h9000, 32'h8000};
        check_log("saturate");

        // Fill gating across a flush, delay 4
        do_flush();
        outlog.delete(); vldq.delete();
        repeat (4) send(16'd100, 4, 1'b1);
        do_flush();
        repeat (5) send(16'd100, 4, 1'b1);
        idle(4);
        litq = '{100, 100, 100, 100, 100, 100, 100, 100, 150};
        check_log("fill_gate");

        // Legal randomized traffic at full rate with mid-flight delay changes
        for (int i = 0; i < 600; i++) begin
            logic [15:0] v;
            v = ($urandom_range(0, 3) == 0) ? (($urandom & 1) ? 16'h7F00 : 16'h8100) : 16'($urandom);
            if ($urandom_range(0, 30) == 0) do_flush();
            send(v, $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
            idle($urandom_range(0, 2));
        end
        idle(4);
        outlog.delete(); vldq.delete();

        // Overrun: back-to-back valids give one output and sticky overrun
        @(posedge clk); #1;
        sample_in = 16'h0100; delay_len = AW'(1); echo_en = 1'b1; sample_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 sample_valid = 1'b0;
        idle(4);
        chk("overrun_outputs", outlog.size(), 1);
        @(negedge clk);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset during FETCH aborts the sample
        @(posedge clk); #1 sample_valid = 1'b1;
        @(posedge clk); #1 sample_valid = 1'b0;
        reset = 1'b1;
        outlog.delete(); vldq.delete();
        @(negedge clk);
        chk("abort_sample_out", int'(sample_out), 0);
        chk("abort_valid", int'(sample_out_valid), 0);
        chk("abort_overrun", int'(overrun), 0);
        chk("abort_busy", int'(busy), 0);
        idle(3); #1 reset = 1'b0;
        idle(3);
        chk("abort_no_pulse", outlog.size(), 0);

        // Unconstrained random traffic including drops and flushes
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            sample_valid = ($urandom_range(0, 99) < 35);
            sample_in    = 16'($urandom);
            delay_len    = AW'($urandom_range(0, 15));
            echo_en      = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        flush        = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
